// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels.
// Imported by the transmit and receive stages.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1, flags the last clock of a bit.
// Ports: clk, rst (async high), restart (clear count), bit_end (last clock of bit).
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, 1-2 stops.
// Ports: clk, rst, in_data/in_valid/in_ready, tx, busy, frame_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_d;
  logic        bit_end;
  logic        accept;
  logic        last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .bit_end(bit_end)
  );

  // In STOP the bit index counts stop bits.
  assign last_stop  = (idx_q == 3'(STOP_BITS - 1));
  assign frame_done = (state_q == STOP) && last_stop && bit_end;
  assign in_ready   = !rst && ((state_q == IDLE) || frame_done);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: ;
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance also covers the last stop cycle: zero-gap frames.
    if (accept) begin
      state_d = START;
      shift_d = in_data;
      par_d   = (^in_data) ^ (PARITY_ODD != 0);
      idx_d   = '0;
    end
    // tx is registered, so it follows the state being entered.
    unique case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = UART_STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      tx      <= UART_STOP_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      tx      <= tx_d;
    end
  end

endmodule
